// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: oversampled start/data/parity/stop framing.
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_frame_ctrl #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_type,
  input  logic                  parity_error,
  output logic [DATA_WIDTH-1:0] data_bits,
  output logic                  parity_bit,
  output logic                  par_chk_en,
  output logic                  par_type_out,
  output logic                  data_valid,
  output logic                  par_err,
`ifdef UART_RX_BREAK_DET_EN
  output logic                  stop_err,
  output logic                  break_det
`else
  output logic                  stop_err
`endif
);

  localparam int EW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [EW-1:0] E_LAST = EW'(OVERSAMPLE - 1);
  localparam logic [EW-1:0] E_V0   = EW'(OVERSAMPLE / 2 - 1);
  localparam logic [EW-1:0] E_V1   = EW'(OVERSAMPLE / 2);
  localparam logic [EW-1:0] E_V2   = EW'(OVERSAMPLE / 2 + 1);
  localparam logic [EW-1:0] E_CAP  = EW'(OVERSAMPLE / 2 + 2);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
`ifdef UART_RX_BREAK_DET_EN
    STOP,
    BREAK_WAIT
`else
    STOP
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic [EW-1:0]           edge_q, edge_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [1:0]              vote_q, vote_d;
  logic                    samp_q, samp_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    pbit_q, pbit_d;
  logic                    pen_q, pen_d;
  logic                    ptype_q, ptype_d;
  logic                    perr_q, perr_d;
  logic                    serr_q, serr_d;
  logic                    sync1_q, rx_s_q;
  logic                    edge_last;
  logic                    maj;
`ifdef UART_RX_BREAK_DET_EN
  logic                    brk_cond;
`endif

  // Two-flop synchroniser; idles high so reset does not look like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      rx_s_q  <= sync1_q;
    end
  end

  assign edge_last = (edge_q == E_LAST);
  assign maj = (vote_q[0] & vote_q[1]) |
               (vote_q[0] & rx_s_q) |
               (vote_q[1] & rx_s_q);

`ifdef UART_RX_BREAK_DET_EN
  assign brk_cond = (data_q == '0) && !(pen_q && pbit_q) && !samp_q;
`endif

  always_comb begin
    state_d    = state_q;
    edge_d     = edge_q;
    bit_d      = bit_q;
    vote_d     = vote_q;
    samp_d     = samp_q;
    data_d     = data_q;
    pbit_d     = pbit_q;
    pen_d      = pen_q;
    ptype_d    = ptype_q;
    perr_d     = perr_q;
    serr_d     = serr_q;
    par_chk_en = 1'b0;
    data_valid = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    break_det  = 1'b0;
`endif

    if (state_q == IDLE) begin
      edge_d = '0;
    end else begin
      edge_d = edge_last ? '0 : edge_q + 1'b1;
      if (edge_q == E_V0) vote_d[0] = rx_s_q;
      if (edge_q == E_V1) vote_d[1] = rx_s_q;
      if (edge_q == E_V2) samp_d = maj;
    end

    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          perr_d  = 1'b0;
          serr_d  = 1'b0;
          pen_d   = par_en;
          ptype_d = par_type;
        end
      end
      START: begin
        if (edge_last) begin
          if (samp_q) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        if (edge_last) begin
          data_d[bit_q] = samp_q;
          if (bit_q == B_LAST) begin
            state_d = pen_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (edge_q == E_CAP) pbit_d = samp_q;
        if (edge_last) begin
          par_chk_en = 1'b1;
          perr_d     = parity_error;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (edge_last) begin
          serr_d     = ~samp_q;
          data_valid = samp_q & ~perr_q;
          state_d    = IDLE;
`ifdef UART_RX_BREAK_DET_EN
          if (brk_cond) begin
            break_det = 1'b1;
            state_d   = BREAK_WAIT;
          end
`endif
        end
      end
`ifdef UART_RX_BREAK_DET_EN
      BREAK_WAIT: begin
        if (rx_s_q) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      edge_q  <= '0;
      bit_q   <= '0;
      vote_q  <= '0;
      samp_q  <= 1'b0;
      data_q  <= '0;
      pbit_q  <= 1'b0;
      pen_q   <= 1'b0;
      ptype_q <= 1'b0;
      perr_q  <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      vote_q  <= vote_d;
      samp_q  <= samp_d;
      data_q  <= data_d;
      pbit_q  <= pbit_d;
      pen_q   <= pen_d;
      ptype_q <= ptype_d;
      perr_q  <= perr_d;
      serr_q  <= serr_d;
    end
  end

  assign data_bits    = data_q;
  assign parity_bit   = pbit_q;
  assign par_type_out = ptype_q;
  assign par_err      = perr_q;
  assign stop_err     = serr_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: frame table plus corner sequences.
// Break-detection checks compile in when UART_RX_BREAK_DET_EN is defined.
module tb_uart_rx_frame_ctrl;

  localparam int OS = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_in = 1'b1;
  logic          par_en = 1'b0;
  logic          par_type = 1'b0;
  logic          stub_err = 1'b0;
  logic          parity_error;
  logic [DW-1:0] data_bits;
  logic          parity_bit;
  logic          par_chk_en;
  logic          par_type_out;
  logic          data_valid;
  logic          par_err;
  logic          stop_err;
`ifdef UART_RX_BREAK_DET_EN
  logic          break_det;
`endif

  assign parity_error = stub_err & par_chk_en;

  uart_rx_frame_ctrl #(.OVERSAMPLE(OS), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (rx_in),
    .par_en       (par_en),
    .par_type     (par_type),
    .parity_error (parity_error),
    .data_bits    (data_bits),
    .parity_bit   (parity_bit),
    .par_chk_en   (par_chk_en),
    .par_type_out (par_type_out),
    .data_valid   (data_valid),
    .par_err      (par_err),
`ifdef UART_RX_BREAK_DET_EN
    .stop_err     (stop_err),
    .break_det    (break_det)
`else
    .stop_err     (stop_err)
`endif
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0 = 0;
  int dv_tot = 0, chk_tot = 0, serr_tot = 0, brk_tot = 0;
  int dv_off = 0, chk_off = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_tot = dv_tot + 1;
      dv_off = cyc - t0;
    end
    if (par_chk_en) begin
      chk_tot = chk_tot + 1;
      chk_off = cyc - t0;
    end
    if (stop_err) serr_tot = serr_tot + 1;
`ifdef UART_RX_BREAK_DET_EN
    if (break_det) brk_tot = brk_tot + 1;
`endif
  end

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pt;
    logic       pb;
    logic       sb;
    logic       err;
    logic       flip;
    int         exp_dv;
    logic       exp_perr;
    logic       exp_serr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_run = n_run + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (OS) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe,
                            input logic pb, input logic sb,
                            input logic flip);
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) begin
      drive_bit(d[i]);
      if (flip && i == 0) begin
        par_en = ~par_en;
        par_type = ~par_type;
      end
    end
    if (pe) drive_bit(pb);
    drive_bit(sb);
  endtask

  int dv0, chk0, serr0, brk0;

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[1] = '{8'h8A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[2] = '{8'h8A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0};
    vecs[6] = '{8'h81, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_data_bits", 32'(data_bits), 0);
    check("rst_par_err", 32'(par_err), 0);
    check("rst_stop_err", 32'(stop_err), 0);
    check("rst_data_valid", 32'(data_valid), 0);
    check("rst_par_type_out", 32'(par_type_out), 0);
    rst = 1'b0;
    idle(4);

    for (int v = 0; v < 7; v++) begin
      par_en   = vecs[v].pe;
      par_type = vecs[v].pt;
      stub_err = vecs[v].err;
      dv0  = dv_tot;
      chk0 = chk_tot;
      send_frame(vecs[v].d, vecs[v].pe, vecs[v].pb, vecs[v].sb,
                 vecs[v].flip);
      idle(16);
      check($sformatf("v%0d_dv_count", v), 32'(dv_tot - dv0),
            32'(vecs[v].exp_dv));
      check($sformatf("v%0d_data_bits", v), 32'(data_bits),
            32'(vecs[v].d));
      check($sformatf("v%0d_par_err", v), 32'(par_err),
            32'(vecs[v].exp_perr));
      check($sformatf("v%0d_stop_err", v), 32'(stop_err),
            32'(vecs[v].exp_serr));
      check($sformatf("v%0d_chk_count", v), 32'(chk_tot - chk0),
            vecs[v].pe ? 32'd1 : 32'd0);
      check($sformatf("v%0d_par_type_out", v), 32'(par_type_out),
            32'(vecs[v].pt));
      if (vecs[v].pe) begin
        check($sformatf("v%0d_parity_bit", v), 32'(parity_bit),
              32'(vecs[v].pb));
        check($sformatf("v%0d_chk_cycle", v), 32'(chk_off), 32'd82);
      end
      if (vecs[v].exp_dv == 1)
        check($sformatf("v%0d_dv_cycle", v), 32'(dv_off),
              vecs[v].pe ? 32'd90 : 32'd82);
    end

    // Start-bit glitch: three low clocks, then a clean frame one bit later
    par_en = 1'b0;
    par_type = 1'b0;
    stub_err = 1'b0;
    dv0  = dv_tot;
    chk0 = chk_tot;
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    idle(9);
    check("glitch_dv", 32'(dv_tot - dv0), 0);
    check("glitch_par_err", 32'(par_err), 0);
    check("glitch_stop_err", 32'(stop_err), 0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(16);
    check("glitch_next_dv", 32'(dv_tot - dv0), 1);
    check("glitch_next_cycle", 32'(dv_off), 82);
    check("glitch_next_data", 32'(data_bits), 32'h5A);

    // Bad stop bit immediately followed by a good frame
    dv0   = dv_tot;
    serr0 = serr_tot;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(16);
    check("b2b_stop_err_seen", 32'(serr_tot - serr0 > 0), 1);
    check("b2b_stop_err_clr", 32'(stop_err), 0);
    check("b2b_dv_count", 32'(dv_tot - dv0), 1);
    check("b2b_dv_cycle", 32'(dv_off), 83);
    check("b2b_data", 32'(data_bits), 32'h55);

    // Reset in the middle of data bit 4
    par_type = 1'b1;
    dv0 = dv_tot;
    t0 = cyc;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_data_bits", 32'(data_bits), 32'h5A);
    check("mid_par_type_out", 32'(par_type_out), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_data_bits", 32'(data_bits), 0);
    check("rst_mid_par_type_out", 32'(par_type_out), 0);
    check("rst_mid_parity_bit", 32'(parity_bit), 0);
    check("rst_mid_stop_err", 32'(stop_err), 0);
    rst = 1'b0;
    par_type = 1'b0;
    idle(100);
    check("rst_mid_no_dv", 32'(dv_tot - dv0), 0);

    // Line held low for 20 bit times
    dv0   = dv_tot;
    serr0 = serr_tot;
    brk0  = brk_tot;
    rx_in = 1'b0;
    repeat (20 * OS) @(negedge clk);
    check("brk_dv", 32'(dv_tot - dv0), 0);
    check("brk_stop_err_seen", 32'(serr_tot - serr0 > 0), 1);
`ifdef UART_RX_BREAK_DET_EN
    check("brk_pulse", 32'(brk_tot - brk0), 1);
    check("brk_stop_err", 32'(stop_err), 1);
    idle(100);
    check("brk_after_pulse", 32'(brk_tot - brk0), 1);
    check("brk_after_dv", 32'(dv_tot - dv0), 0);
    check("brk_after_stop_err", 32'(stop_err), 1);
`else
    idle(200);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    check("brk_final_stop_err", 32'(stop_err), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
UART receive front end that sits directly upstream of parity_check. It oversamples the serial line, detects and validates the start bit, deserialises data LSB-first and captures the parity bit. It drives data_bits/parity_bit/par_chk_en into parity_check and consumes its parity_error. It then checks the stop bit and emits a one-cycle data_valid for good frames.

Parameters:
OVERSAMPLE, 8, clocks per bit; even, 8..32
DATA_WIDTH, 8, data bits per frame

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
rx_in  input  1  asynchronous serial line, idle high
par_en  input  1  1 = frame carries a parity bit
par_type  input  1  passed through to parity_check (0 even, 1 odd)
parity_error  input  1  from parity_check, combinational
data_bits  output  DATA_WIDTH  deserialised byte, to parity_check and consumer
parity_bit  output  1  received parity bit, to parity_check
par_chk_en  output  1  parity-check strobe, to parity_check
par_type_out  output  1  registered copy of par_type, captured at frame start
data_valid  output  1  one-cycle pulse, frame good
par_err  output  1  sticky per frame, parity failed
stop_err  output  1  sticky per frame, stop bit sampled 0

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; all outputs 0 except the synchroniser flops, which reset to 1; counters 0. Reset mid-frame aborts the frame with no data_valid.
- rx_in passes through a 2-flop synchroniser (reset 1), giving rx_s. There are 2 cycles of latency from pin to FSM.
- edge_cnt counts 0..OVERSAMPLE-1 within each bit period. bit_cnt counts 0..DATA_WIDTH-1 in DATA.
- Sampling: majority vote of rx_s at edge_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The vote is registered as samp_bit, valid from edge_cnt = OVERSAMPLE/2+2.
- States:
  - IDLE: when rx_s=0, go to START with edge_cnt=0 that cycle. Clear par_err and stop_err. Capture par_en and par_type.
  - START: at edge_cnt=OVERSAMPLE-1, if samp_bit=1 (glitch), go to IDLE with no error flagged. Otherwise go to DATA with bit_cnt=0.
  - DATA: at edge_cnt=OVERSAMPLE-1, write samp_bit into data_bits[bit_cnt] (LSB first).
    - If bit_cnt=DATA_WIDTH-1, go to PARITY if par_en was captured, else STOP.
    - Otherwise increment bit_cnt.
  - PARITY: at edge_cnt=OVERSAMPLE/2+2, parity_bit<=samp_bit. At edge_cnt=OVERSAMPLE-1, par_chk_en=1 for exactly that cycle, par_err<=parity_error in the same cycle, then go to STOP.
  - STOP: at edge_cnt=OVERSAMPLE-1:
    - stop_err<=~samp_bit.
    - data_valid=1 in that cycle iff samp_bit=1 and par_err=0.
    - Go to IDLE.
- par_chk_en is 0 at all other times, and never asserts when par_en=0.
- data_bits and parity_bit hold their values from frame end until overwritten by the next frame's DATA/PARITY states.
- Changes to par_en or par_type mid-frame are ignored; the captured values apply.
- A new start bit may begin the cycle after STOP returns to IDLE (back-to-back frames, zero idle bits).
- A frame with stop_err leaves data_valid=0. par_err and stop_err stay visible until the next START.

Optional Feature:
UART_RX_BREAK_DET_EN
- Defined: adds output break_det (1 bit, reset 0). If data_bits are all 0, the parity bit (if present) is 0 and the stop sample is 0:
  - break_det pulses 1 cycle at the end of STOP and stop_err=1;
  - the FSM enters BREAK_WAIT and stays there until rx_s=1, then goes to IDLE.
- Undefined: no break_det port and no BREAK_WAIT state. A break is reported as stop_err only. The FSM returns to IDLE and restarts on the still-low line (repeated errored frames).

Test Plan:
1. OVERSAMPLE=8, par_en=0, send 0x A5 (start, 1,0,1,0,0,1,0,1 LSB-first, stop=1) -> data_valid pulses once 80 clks after start edge (+2 sync), data_bits=0xA5, par_chk_en never 1.
2. par_en=1, par_type=0, byte 0x8A, parity bit 1 (even OK) with parity_check stub returning 0 -> par_chk_en single pulse at end of parity bit, parity_bit=1, data_valid=1, par_err=0.
3. Same frame with parity_check stub returning 1 at the strobe -> par_err=1, data_valid=0, data_bits=0x8A still valid.
4. rx_in low for 3 clks then high (start glitch) -> FSM back in IDLE after one bit period, no data_valid, no error flags.
5. Byte 0x3C with stop bit 0 -> stop_err=1, data_valid=0. A following correct frame 0x55 sent back-to-back -> stop_err cleared at START, data_valid=1, data_bits=0x55.
6. Assert rst during DATA bit 4 -> all outputs 0 on next edge, no data_valid. With UART_RX_BREAK_DET_EN, hold rx_in low 20 bit times -> one break_det pulse, no further frames until line high.
